// File: rtl/ram_4w16b.sv
// 4-word x WIDTH-bit register-file RAM: synchronous write, combinational read on a shared address.
// Optional RAM_4W16B_WRITE_THROUGH_EN forwards pending write data straight to out.
module ram_4w16b #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    output logic [WIDTH-1:0]  out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] word_sel;
    logic [WIDTH-1:0] rd_words [DEPTH];
    logic [WIDTH-1:0] rd_data;

    // One register per word; each word only loads when it is the decoded target.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_q;
            logic [WIDTH-1:0] word_d;

            assign word_sel[gi] = (addr == ADDR_W'(gi));

            always_comb begin
                word_d = word_q;
                if (load && word_sel[gi]) begin
                    word_d = in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign rd_words[gi] = word_q;
        end
    endgenerate

    assign rd_data = rd_words[addr];

`ifdef RAM_4W16B_WRITE_THROUGH_EN
    assign out = (load && !rst) ? in : rd_data;
`else
    assign out = rd_data;
`endif

endmodule

// File: tb/tb_ram_4w16b.sv
// Self-checking bench for ram_4w16b (default build): scoreboard queue of expected reads.
module tb_ram_4w16b;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [1:0]  addr;
    logic        load;
    logic [15:0] out;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q [$];

    ram_4w16b #(.WIDTH(16), .ADDR_W(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .addr (addr),
        .load (load),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the next rising edge and step off it before touching inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst = 1'b1; load = 1'b0; in = 16'h0; addr = 2'd0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            exp_q.push_back(16'h0000);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d got=%h exp=%h", a, out, e);
            end else
                $display("reset_read addr=%0d out=%h", a, out);
        end
    endtask

    task automatic test_read_before_write();
        logic [15:0] e;
        in = 16'h5555; addr = 2'd0; load = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h5555);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin
            n_fail++;
            $display("FAIL rbw_before got=%h exp=%h", out, e);
        end else
            $display("rbw_before out=%h", out);
        tick();
        load = 1'b0; in = 16'h0;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin
            n_fail++;
            $display("FAIL rbw_after got=%h exp=%h", out, e);
        end else
            $display("rbw_after out=%h", out);
    endtask

    task automatic test_write_isolation();
        logic [15:0] e;
        in = 16'hFFFF; addr = 2'd1; load = 1'b1;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h5555);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin
            n_fail++;
            $display("FAIL iso_before got=%h exp=%h", out, e);
        end else
            $display("iso_before out=%h", out);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin
            n_fail++;
            $display("FAIL iso_after got=%h exp=%h", out, e);
        end else
            $display("iso_after out=%h", out);
        load = 1'b0; in = 16'h0; addr = 2'd0;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin
            n_fail++;
            $display("FAIL iso_neighbour got=%h exp=%h", out, e);
        end else
            $display("iso_neighbour out=%h", out);
    endtask

    task automatic test_back_to_back_fill();
        logic [15:0] vals [4];
        logic [15:0] e;
        vals[0] = 16'h5555; vals[1] = 16'hFFFF; vals[2] = 16'hAAAA; vals[3] = 16'h0FF0;
        // Consecutive write edges, one per address.
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); in = vals[a]; load = 1'b1;
            tick();
        end
        load = 1'b0; in = 16'h0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            for (int c = 0; c < 2; c++) begin
                exp_q.push_back(vals[a]);
                tick();
                e = exp_q.pop_front();
                n_checks++;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL fill_read addr=%0d cyc=%0d got=%h exp=%h", a, c, out, e);
                end else
                    $display("fill_read addr=%0d cyc=%0d out=%h", a, c, out);
            end
        end
    endtask

    task automatic test_load_protect();
        logic [15:0] e;
        in = 16'h1234; load = 1'b0; addr = 2'd2;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(16'hAAAA);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL load_protect cyc=%0d got=%h exp=%h", c, out, e);
            end else
                $display("load_protect cyc=%0d out=%h", c, out);
        end
        // The other words must also be untouched by the idle edges.
        addr = 2'd3;
        exp_q.push_back(16'h0FF0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (out !== e) begin
            n_fail++;
            $display("FAIL load_protect_w3 got=%h exp=%h", out, e);
        end else
            $display("load_protect_w3 out=%h", out);
    endtask

    task automatic test_reset_priority();
        logic [15:0] e;
        rst = 1'b1; load = 1'b1; in = 16'hBEEF; addr = 2'd3;
        tick();
        rst = 1'b0; load = 1'b0; in = 16'h0;
        for (int a = 3; a >= 0; a--) begin
            addr = 2'(a);
            exp_q.push_back(16'h0000);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (out !== e) begin
                n_fail++;
                $display("FAIL rst_priority addr=%0d got=%h exp=%h", a, out, e);
            end else
                $display("rst_priority addr=%0d out=%h", a, out);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; load = 1'b0; in = 16'h0; addr = 2'd0;
        test_reset();
        test_read_before_write();
        test_write_isolation();
        test_back_to_back_fill();
        test_load_protect();
        test_reset_priority();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
